// File: rtl/stage5_sequencer.sv
// rtl/stage5_sequencer.sv - execute-stage control FSM sequencing one or two ALU passes per operation
module stage5_sequencer (
    input  logic       CLK,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic [1:0] cond,
    input  logic [1:0] SRout,
    input  logic       flush,
    output logic [1:0] ALUsrcA,
    output logic [1:0] ALUsrcB,
    output logic [1:0] ALUop,
    output logic       ALU_in,
    output logic       SRw,
    output logic [1:0] isDecode,
    output logic       busy,
    output logic       done,
    output logic       taken,
    output logic       illegal
);
    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_AND = 2'b10;
    localparam logic [1:0] ALUOP_OR  = 2'b11;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_ADDI  = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_CMP   = 3'b100;
    localparam logic [2:0] OP_INCPC = 3'b101;
    localparam logic [2:0] OP_BR    = 3'b110;
    localparam logic [2:0] OP_ILL   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_WB    = 3'd2,
        S_EXEC2 = 3'd3,
        S_WB2   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t     state;
    logic [2:0] op_q;
    logic [1:0] cond_q;
    logic       taken_q;
    logic       cond_met;
    logic       wb_alu_in;
    logic       wb_srw;

    // SRout holds the compare result by the time EXEC2 is reached
    always_comb begin
        cond_met = 1'b0;
        case (cond_q)
            2'b00: cond_met = 1'b1;
            2'b01: cond_met = SRout[0];
            2'b10: cond_met = SRout[1];
            2'b11: cond_met = ~SRout[0];
            default: cond_met = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            op_q    <= 3'b000;
            cond_q  <= 2'b00;
            taken_q <= 1'b0;
        end else if (flush && state != S_IDLE) begin
            state   <= S_IDLE;
            taken_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    taken_q <= 1'b0;
                    if (start && !flush) begin
                        op_q   <= opcode;
                        cond_q <= cond;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC:  state <= (op_q == OP_ILL) ? S_DONE : S_WB;
                S_WB:    state <= (op_q == OP_BR) ? S_EXEC2 : S_DONE;
                S_EXEC2: begin
                    taken_q <= cond_met;
                    state   <= S_WB2;
                end
                S_WB2:   state <= S_DONE;
                S_DONE: begin
                    taken_q <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ALUsrcA   = 2'd0;
        ALUsrcB   = 2'd0;
        ALUop     = ALUOP_ADD;
        isDecode  = 2'd0;
        wb_alu_in = 1'b0;
        wb_srw    = 1'b0;
        case (state)
            S_EXEC, S_WB: begin
                case (op_q)
                    OP_ADD:   begin ALUsrcB = 2'd1; ALUop = ALUOP_ADD; end
                    OP_SUB:   begin ALUsrcB = 2'd1; ALUop = ALUOP_SUB; end
                    OP_ADDI:  begin ALUsrcA = 2'd1; ALUsrcB = 2'd1; ALUop = ALUOP_ADD; end
                    OP_AND:   begin ALUsrcB = 2'd1; ALUop = ALUOP_AND; end
                    OP_CMP,
                    OP_BR:    begin ALUsrcB = 2'd1; ALUop = ALUOP_SUB; end
                    OP_INCPC: begin ALUsrcA = 2'd3; ALUsrcB = 2'd2; ALUop = ALUOP_ADD; end
                    default:  ALUop = ALUOP_ADD;
                endcase
                if (state == S_WB) begin
                    wb_alu_in = (op_q != OP_CMP) && (op_q != OP_BR) && (op_q != OP_ILL);
                    wb_srw    = (op_q != OP_INCPC) && (op_q != OP_ILL);
                end
            end
            S_EXEC2, S_WB2: begin
                // Taken branches load the IR address; otherwise compute PC+2
                if ((state == S_EXEC2) ? cond_met : taken_q) begin
                    isDecode = 2'd1;
                end else begin
                    ALUsrcA = 2'd3;
                    ALUsrcB = 2'd2;
                    ALUop   = ALUOP_ADD;
                end
                wb_alu_in = (state == S_WB2);
            end
            default: ;
        endcase
    end

    assign ALU_in  = wb_alu_in & ~flush;
    assign SRw     = wb_srw & ~flush;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign illegal = (state == S_DONE) && (op_q == OP_ILL);
    assign taken   = taken_q;
endmodule

// File: tb/tb_stage5_sequencer.sv
// tb/tb_stage5_sequencer.sv - self-checking bench for stage5_sequencer against a cycle-table model
module tb_stage5_sequencer;
    logic       CLK = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] opcode;
    logic [1:0] cond;
    logic [1:0] SRout;
    logic       flush;
    logic [1:0] ALUsrcA;
    logic [1:0] ALUsrcB;
    logic [1:0] ALUop;
    logic       ALU_in;
    logic       SRw;
    logic [1:0] isDecode;
    logic       busy;
    logic       done;
    logic       taken;
    logic       illegal;
    logic [13:0] obs;

    int tests = 0;
    int fails = 0;

    stage5_sequencer dut (
        .CLK(CLK), .reset(reset), .start(start), .opcode(opcode), .cond(cond),
        .SRout(SRout), .flush(flush), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB),
        .ALUop(ALUop), .ALU_in(ALU_in), .SRw(SRw), .isDecode(isDecode),
        .busy(busy), .done(done), .taken(taken), .illegal(illegal)
    );

    always #5 CLK = ~CLK;

    assign obs = {ALUsrcA, ALUsrcB, ALUop, ALU_in, SRw, isDecode, busy, done, taken, illegal};

    function automatic int op_len(input logic [2:0] opc);
        if (opc == 3'd7) return 2;
        if (opc == 3'd6) return 5;
        return 3;
    endfunction

    // Expected outputs in cycle cyc (1 = first cycle after the start edge)
    function automatic logic [13:0] model(input logic [2:0] opc, input logic [1:0] cnd,
                                          input logic [1:0] sr, input int cyc);
        logic [1:0] a, b, o, isd;
        logic wa, ws, al, sw, bz, dn, tk, il, met;
        a = 0; b = 0; o = 0; isd = 0;
        wa = 0; ws = 0; al = 0; sw = 0; bz = 0; dn = 0; tk = 0; il = 0;
        case (opc)
            3'd0: begin a = 0; b = 1; o = 0; wa = 1; ws = 1; end
            3'd1: begin a = 0; b = 1; o = 1; wa = 1; ws = 1; end
            3'd2: begin a = 1; b = 1; o = 0; wa = 1; ws = 1; end
            3'd3: begin a = 0; b = 1; o = 2; wa = 1; ws = 1; end
            3'd4: begin a = 0; b = 1; o = 1; wa = 0; ws = 1; end
            3'd5: begin a = 3; b = 2; o = 0; wa = 1; ws = 0; end
            3'd6: begin a = 0; b = 1; o = 1; wa = 0; ws = 1; end
            default: ;
        endcase
        met = (cnd == 0) || (cnd == 1 && sr[0]) || (cnd == 2 && sr[1]) || (cnd == 3 && !sr[0]);
        if (cyc <= op_len(opc)) begin
            bz = 1;
            if (cyc == op_len(opc)) begin
                dn = 1;
                il = (opc == 3'd7);
                tk = (opc == 3'd6) && met;
                a = 0; b = 0; o = 0;
            end else if (cyc <= 2) begin
                if (cyc == 2) begin al = wa; sw = ws; end
            end else begin
                a = 0; b = 0; o = 0;
                if (met) isd = 1;
                else begin a = 3; b = 2; o = 0; end
                al = (cyc == 4);
            end
        end else begin
            a = 0; b = 0; o = 0;
        end
        return {a, b, o, al, sw, isd, bz, dn, tk, il};
    endfunction

    task automatic run_op(input logic [2:0] opc, input logic [1:0] cnd, input logic [1:0] sr,
                          input bit noisy, input string name);
        logic [13:0] exp, mask;
        int len;
        len = op_len(opc);
        @(negedge CLK);
        start = 1; opcode = opc; cond = cnd; SRout = sr; flush = 0;
        for (int c = 1; c <= len + 1; c++) begin
            @(negedge CLK);
            exp = model(opc, cnd, sr, c);
            mask = '1;
            if (opc == 3'd6 && c == 4) mask[1] = 1'b0;
            tests++;
            if (((obs ^ exp) & mask) !== 14'd0) begin
                fails++;
                $display("FAIL %s op=%0d cond=%0d sr=%0d cyc=%0d: got %h expected %h",
                         name, opc, cnd, sr, c, obs, exp);
            end
            if (noisy && c <= len) begin
                start = 1'($urandom); opcode = 3'($urandom); cond = 2'($urandom);
            end else begin
                start = 0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 0; start = 0; flush = 0; opcode = 0; cond = 0; SRout = 0;
        @(negedge CLK);
        tests++;
        if (obs !== 14'd0) begin fails++; $display("FAIL reset_state: got %h expected 0", obs); end
        reset = 1;
        @(negedge CLK);
        start = 1; opcode = 3'd0;
        @(negedge CLK);
        start = 0;
        @(negedge CLK);
        tests++;
        if (ALU_in !== 1'b1 || SRw !== 1'b1) begin
            fails++; $display("FAIL reset_pre_wb: got ALU_in=%b SRw=%b expected 1 1", ALU_in, SRw);
        end
        reset = 0;
        #1;
        tests++;
        if (obs !== 14'd0) begin fails++; $display("FAIL reset_async: got %h expected 0", obs); end
        @(negedge CLK);
        reset = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            tests++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                fails++; $display("FAIL reset_after: busy=%b done=%b expected 0 0", busy, done);
            end
        end
    endtask

    task automatic test_directed();
        run_op(3'd0, 2'd0, 2'd0, 0, "add");
        run_op(3'd4, 2'd0, 2'd0, 0, "cmp");
        run_op(3'd5, 2'd0, 2'd0, 0, "incpc");
        run_op(3'd6, 2'd1, 2'd1, 0, "br_taken");
        run_op(3'd6, 2'd1, 2'd0, 0, "br_not_taken");
        run_op(3'd7, 2'd0, 2'd0, 0, "illegal");
    endtask

    task automatic test_flush();
        @(negedge CLK);
        start = 1; opcode = 3'd1;
        @(negedge CLK);
        start = 0;
        @(negedge CLK);
        flush = 1;
        #1;
        tests++;
        if (ALU_in !== 1'b0 || SRw !== 1'b0) begin
            fails++; $display("FAIL flush_gate: got ALU_in=%b SRw=%b expected 0 0", ALU_in, SRw);
        end
        @(negedge CLK);
        flush = 0;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (busy !== 1'b0 || done !== 1'b0 || illegal !== 1'b0) begin
                fails++; $display("FAIL flush_idle: busy=%b done=%b illegal=%b expected 0 0 0",
                                  busy, done, illegal);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_start_flush_idle();
        @(negedge CLK);
        start = 1; flush = 1; opcode = 3'd0;
        @(negedge CLK);
        start = 0; flush = 0;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL start_flush: busy=%b expected 0", busy); end
        @(negedge CLK);
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL start_flush_done: done=%b expected 0", done); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 150; i++) begin
            run_op(3'($urandom), 2'($urandom), 2'($urandom), 1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_start_flush_idle();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stage5_sequencer.md
Name: stage5_sequencer

Overview:
- Multi-cycle control FSM that drives the execute stage: ALU source A/B selects, ALU op, ALU output register write, status register write and the ALU-output source select.
- Accepts one decoded operation per start/done handshake.
- Sequences one or two ALU passes per operation. Branches take two passes: a compare, then a target or PC+2 selection that depends on the status flags produced by the compare.

Parameters:
- ALUOP_ADD, 2'b00, ALU op code for add
- ALUOP_SUB, 2'b01, ALU op code for subtract
- ALUOP_AND, 2'b10, ALU op code for and
- ALUOP_OR, 2'b11, ALU op code for or (reserved, not issued)

Ports:
- CLK  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- start  in  1  request; sampled only in IDLE
- opcode  in  3  operation, captured with start
- cond  in  2  branch condition, captured with start
- SRout  in  2  status register value; [1]=N, [0]=Z
- flush  in  1  synchronous abort
- ALUsrcA  out  2  0=MDR, 1=imm, 2=CC, 3=PC
- ALUsrcB  out  2  0=SR, 1=reg, 2=const 2, 3=ALU output (never issued)
- ALUop  out  2  ALU operation
- ALU_in  out  1  ALU output register write strobe
- SRw  out  1  status register write strobe
- isDecode  out  2  ALU-output source: 0=ALU, 1=IR address
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- taken  out  1  branch outcome; valid with done
- illegal  out  1  one-cycle pulse with done for opcode 111

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; captured opcode/cond cleared.
  - All outputs read 0.
- States: IDLE, EXEC, WB, EXEC2, WB2, DONE.
- Handshake:
  - In IDLE, start=1 captures opcode/cond; next state is EXEC.
  - start is ignored whenever busy=1.
- Opcode decode; selects are driven in EXEC and held in WB:
  - 000 ADD: A=0, B=1, op ADD; WB asserts ALU_in and SRw.
  - 001 SUB: A=0, B=1, op SUB; WB asserts ALU_in and SRw.
  - 010 ADDI: A=1, B=1, op ADD; WB asserts ALU_in and SRw.
  - 011 AND: A=0, B=1, op AND; WB asserts ALU_in and SRw.
  - 100 CMP: A=0, B=1, op SUB; WB asserts SRw only.
  - 101 INCPC: A=3, B=2, op ADD; WB asserts ALU_in only.
  - 110 BR: pass 1 (EXEC/WB) is identical to CMP; then WB goes to EXEC2.
  - 111: EXEC goes directly to DONE; no strobes; illegal=1 in DONE.
- Strobes: ALU_in and SRw are high only in WB or WB2, for exactly one cycle each.
- Non-branch sequence: EXEC, then WB, then DONE. done is high in DONE, 3 cycles after the start edge. DONE goes to IDLE.
- Branch second pass:
  - In EXEC2, evaluate the condition on SRout, which by then holds the compare result.
  - cond 00: always; 01: Z=1; 10: N=1; 11: Z=0.
  - Taken: isDecode=1 through EXEC2 and WB2; WB2 asserts ALU_in; ALU output register loads the IR address.
  - Not taken: A=3, B=2, op ADD, isDecode=0; WB2 asserts ALU_in.
  - The outcome is registered at the EXEC2 to WB2 edge. taken is held through DONE and cleared on return to IDLE.
  - Branch done comes 5 cycles after the start edge.
- flush:
  - Any state other than IDLE goes to IDLE on the next edge. No done, no illegal.
  - flush=1 gates ALU_in and SRw low in the same cycle.
  - flush and start together in IDLE: flush wins and start is dropped.
- Reset mid-operation: the operation is abandoned and no done is issued.
- In IDLE and DONE, selects, ALUop and isDecode are 0.
- Outputs are decoded from registered state and captured fields only. There is no combinational path from start, opcode or cond to any output.

Test Plan:
- Reset: hold reset=0 mid-WB of an ADD -> all outputs 0 at once; after release, busy=0 and no done.
- ADD: start with opcode=000 -> cycle 1 A=0/B=1/op=00, strobes 0; cycle 2 ALU_in=1, SRw=1; cycle 3 done=1, busy=1; cycle 4 busy=0.
- CMP and INCPC: CMP gives SRw=1, ALU_in=0 in WB. INCPC gives A=3, B=2, ALU_in=1, SRw=0. Each completes with done in cycle 3.
- Branch: cond=01 with SRout=01 -> isDecode=1 and ALU_in=1 in cycle 4, done and taken=1 in cycle 5. Repeat with SRout=00 -> A=3/B=2, taken=0.
- flush asserted in WB of SUB -> ALU_in=0 and SRw=0 that cycle, IDLE next, no done. start with opcode=111 -> done=1 and illegal=1 in cycle 2, no strobes.
- start held high during busy -> exactly one operation executes. Simultaneous flush+start in IDLE -> remains IDLE.
